step_sequencer: RTL and testbench



---
 rtl/step_sequencer.sv | 155 +++++++++++++++
 tb/tb_step_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: clears a small FSM datapath, then steps it a programmed
// number of times. One sample of the datapath output y is taken on every step,
// and the samples are packed into a pattern word. Status is reported through a
// start/busy/done handshake.
//
// Every output is either a register or a decode of the state register, so no
// input reaches an output combinationally. Because of this, step_en is
// registered. hold and abort are sampled on the edge that opens a cycle, and
// step_en for that cycle reflects them. A datapath step takes place on every
// edge at which step_en is high, and y_in is sampled on that same edge.
module step_sequencer #(
   parameter int CNT_W = 8,
   parameter int PAT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] step_count,
   input  logic             hold,
   input  logic             abort,
   input  logic             y_in,
   output logic             dp_clear,
   output logic             step_en,
   output logic             busy,
   output logic             done,
   output logic [PAT_W-1:0] pattern,
   output logic             pattern_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] remaining_reg;
   logic [PAT_W-1:0] pattern_reg;
   logic             pattern_valid_reg;
   logic             step_en_reg;

   logic             accept;
   logic             zero_run;
   logic             step_fire;
   logic             last_step;

   // Decode the events for this edge: an accepted start, and a datapath step
   // that actually counts (abort overrides it).
   always_comb begin
      accept    = 1'b0;
      zero_run  = 1'b0;
      step_fire = 1'b0;
      last_step = 1'b0;
      if (state_reg == IDLE && start) begin
         accept   = 1'b1;
         zero_run = (step_count == CNT_ZERO);
      end
      if (state_reg == RUN && step_en_reg && !abort) begin
         step_fire = 1'b1;
         last_step = (remaining_reg == CNT_ONE);
      end
   end

   // Next-state logic. abort wins over the final step and over hold.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = zero_run ? DONE : CLEAR;
            end
         end
         CLEAR: begin
            state_next = abort ? IDLE : RUN;
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Step enable for the coming cycle: active only while running and not held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_en_reg <= 1'b0;
      end else begin
         step_en_reg <= (state_next == RUN) && !hold;
      end
   end

   // Remaining-steps counter. It is latched on accept, and it counts down on each real step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining_reg <= CNT_ZERO;
      end else if (accept) begin
         remaining_reg <= step_count;
      end else if (step_fire) begin
         remaining_reg <= remaining_reg - CNT_ONE;
      end
   end

   // Pattern shift register. The newest y sample enters at bit 0. An aborted run leaves its partial capture in place.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern_reg <= '0;
      end else if (accept) begin
         pattern_reg <= '0;
      end else if (step_fire) begin
         pattern_reg <= {pattern_reg[PAT_W-2:0], y_in};
      end
   end

   // Result-valid flag. It is set on entry to DONE, so it is already high alongside done. It is cleared by the next accepted start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern_valid_reg <= 1'b0;
      end else if (state_next == DONE) begin
         pattern_valid_reg <= 1'b1;
      end else if (accept) begin
         pattern_valid_reg <= 1'b0;
      end
   end

   assign dp_clear      = (state_reg == CLEAR);
   assign busy          = (state_reg == CLEAR) || (state_reg == RUN);
   assign done          = (state_reg == DONE);
   assign step_en       = step_en_reg;
   assign pattern       = pattern_reg;
   assign pattern_valid = pattern_valid_reg;

endmodule

// File: tb/tb_step_sequencer.sv
// Testbench for step_sequencer. A behavioural model keeps the collected y
// samples in a queue and tracks which phase the run is in. After every clock
// edge, all DUT outputs are compared with the model's outputs. Directed cases
// pin literal values first, and then a randomized run follows.
module tb_step_sequencer;

   localparam int CNT_W = 8;
   localparam int PAT_W = 8;

   logic             clk;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] step_count;
   logic             hold;
   logic             abort;
   logic             y_in;
   logic             dp_clear;
   logic             step_en;
   logic             busy;
   logic             done;
   logic [PAT_W-1:0] pattern;
   logic             pattern_valid;

   step_sequencer #(.CNT_W(CNT_W), .PAT_W(PAT_W)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .step_count(step_count),
      .hold(hold),
      .abort(abort),
      .y_in(y_in),
      .dp_clear(dp_clear),
      .step_en(step_en),
      .busy(busy),
      .done(done),
      .pattern(pattern),
      .pattern_valid(pattern_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model phases: 0 idle, 1 clearing, 2 stepping, 3 finished.
   int   m_mode;
   int   m_left;
   bit   m_sen;
   bit   m_pv;
   bit   m_q[$];

   int   sen_cnt;
   int   done_cnt;
   int   cyc;
   int   done_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   // The pattern holds the last PAT_W samples, with the newest sample at bit 0.
   function automatic logic [PAT_W-1:0] model_pat();
      logic [PAT_W-1:0] p;
      int n;
      int s;
      p = '0;
      n = m_q.size();
      s = (n > PAT_W) ? n - PAT_W : 0;
      for (int i = s; i < n; i++) p = {p[PAT_W-2:0], m_q[i]};
      return p;
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_left = 0;
      m_sen  = 0;
      m_pv   = 0;
      m_q.delete();
   endtask

   task automatic compare_all();
      check("dp_clear", 32'(dp_clear), 32'(m_mode == 1));
      check("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      check("done", 32'(done), 32'(m_mode == 3));
      check("step_en", 32'(step_en), 32'(m_sen));
      check("pattern", 32'(pattern), 32'(model_pat()));
      check("pattern_valid", 32'(pattern_valid), 32'(m_pv));
   endtask

   // Drive one cycle of inputs and let the clock edge happen. Then advance the model and compare.
   task automatic tick(input logic s, input logic [CNT_W-1:0] sc, input logic h,
                       input logic a, input logic yy);
      int nm;
      start = s; step_count = sc; hold = h; abort = a; y_in = yy;
      @(posedge clk);
      nm = m_mode;
      case (m_mode)
         0: begin
            if (s) begin
               m_q.delete();
               m_pv = 0;
               if (sc != 0) begin
                  m_left = int'(sc);
                  nm = 1;
               end else begin
                  nm = 3;
               end
            end
         end
         1: nm = a ? 0 : 2;
         2: begin
            if (a) nm = 0;
            else if (m_sen) begin
               m_q.push_back(yy);
               m_left--;
               nm = (m_left == 0) ? 3 : 2;
            end
         end
         default: nm = 0;
      endcase
      if (nm == 3) m_pv = 1;
      m_sen  = (nm == 2) && !h;
      m_mode = nm;
      #1;
      cyc++;
      if (step_en) sen_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      compare_all();
      $display("tick t=%0t st=%0b sc=%0d h=%0b a=%0b y=%0b | clr=%0b en=%0b busy=%0b done=%0b pat=%02h pv=%0b",
               $time, s, sc, h, a, yy, dp_clear, step_en, busy, done, pattern, pattern_valid);
   endtask

   task automatic idle_tick();
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   // Assert reset between clock edges. The outputs must clear without waiting for a clock edge.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      #1;
      reset = 1'b0;
      $display("reset pulse t=%0t", $time);
   endtask

   initial begin
      logic [3:0] yv;
      reset = 1'b1; start = 0; step_count = 0; hold = 0; abort = 0; y_in = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      reset = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 10; i++) idle_tick();

      // step_count=4, y = 1,0,1,1 -> 8'h0B
      yv = 4'b1011;
      cyc = 0; sen_cnt = 0; done_cnt = 0; done_cyc = -1;
      tick(1'b1, 8'd4, 0, 0, 0);
      check("lit_clear_c1", 32'(dp_clear), 32'd1);
      idle_tick();
      check("lit_en_c2", 32'(step_en), 32'd1);
      for (int i = 3; i >= 0; i--) tick(0, '0, 0, 0, yv[i]);
      check("lit_done_c6", 32'(done), 32'd1);
      check("lit_pat_0b", 32'(pattern), 32'h0B);
      check("lit_pv", 32'(pattern_valid), 32'd1);
      check("lit_steps4", 32'(sen_cnt), 32'd4);
      check("lit_done_cyc", 32'(done_cyc), 32'd6);
      idle_tick();

      // step_count=3 with hold sampled at the edge opening cycle 3
      cyc = 0; sen_cnt = 0; done_cyc = -1;
      tick(1, 8'd3, 0, 0, 0);
      tick(0, '0, 0, 0, 0);
      tick(0, '0, 1, 0, 1);
      check("lit_hold_en_c3", 32'(step_en), 32'd0);
      for (int i = 0; i < 4; i++) tick(0, '0, 0, 0, 1);
      check("lit_hold_done_c6", 32'(done_cyc), 32'd6);
      check("lit_hold_steps3", 32'(sen_cnt), 32'd3);
      check("lit_hold_pat", 32'(pattern), 32'h07);

      // step_count=0: finishes at once with no datapath activity
      cyc = 0; sen_cnt = 0; done_cyc = -1;
      tick(1, 8'd0, 0, 0, 1);
      check("lit_zero_done", 32'(done), 32'd1);
      check("lit_zero_pat", 32'(pattern), 32'd0);
      check("lit_zero_pv", 32'(pattern_valid), 32'd1);
      check("lit_zero_noclr", 32'(dp_clear), 32'd0);
      idle_tick();

      // step_count=10, abort in cycle 5
      cyc = 0; done_cnt = 0;
      tick(1, 8'd10, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, '0, 0, 0, 1);
      tick(0, '0, 0, 1, 1);
      check("lit_abort_busy", 32'(busy), 32'd0);
      check("lit_abort_en", 32'(step_en), 32'd0);
      check("lit_abort_pv", 32'(pattern_valid), 32'd0);
      tick(1, 8'd2, 0, 0, 0);
      check("lit_restart_clr", 32'(dp_clear), 32'd1);
      for (int i = 0; i < 4; i++) idle_tick();
      check("lit_abort_one_done", 32'(done_cnt), 32'd1);

      // start pulsed during RUN is ignored
      sen_cnt = 0; done_cnt = 0;
      tick(1, 8'd5, 0, 0, 0);
      idle_tick();
      tick(1, 8'd2, 0, 0, 1);
      for (int i = 0; i < 6; i++) tick(0, 8'd1, 0, 0, 0);
      check("lit_ignore_steps5", 32'(sen_cnt), 32'd5);
      check("lit_ignore_done1", 32'(done_cnt), 32'd1);

      // asynchronous reset mid-RUN, then a normal run
      tick(1, 8'd6, 0, 0, 1);
      idle_tick();
      tick(0, '0, 0, 0, 1);
      async_reset();
      check("lit_rst_busy", 32'(busy), 32'd0);
      done_cnt = 0;
      tick(1, 8'd2, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick(0, '0, 0, 0, 1);
      check("lit_rst_run_done", 32'(done_cnt), 32'd1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [CNT_W-1:0] sc;
         sc = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 40)) : CNT_W'($urandom_range(0, 12));
         if ($urandom_range(0, 400) == 0) async_reset();
         tick($urandom_range(0, 3) == 0, sc, $urandom_range(0, 3) == 0,
              $urandom_range(0, 29) == 0, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
